// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline.
//   Stage 1 captures the operands and opcode; the operation is executed while
//   moving from stage 1 into stage 2, which drives Z and FLAGS.
// Ports:
//   CLOCK      in   rising-edge clock
//   RESET_N    in   synchronous active-low reset
//   IN_VALID   in   A, B, INST are valid this cycle
//   IN_READY   out  an operation is accepted this cycle (combinational from OUT_READY)
//   A, B       in   WIDTH-bit operands (subtract is A-B)
//   INST       in   4-bit opcode
//   OUT_VALID  out  Z and FLAGS hold a result
//   OUT_READY  in   consumer takes the result this cycle
//   Z          out  WIDTH-bit result
//   FLAGS      out  {sticky overflow, zero, carry, overflow}
module alu_pipe #(
    parameter int WIDTH      = 32,
    parameter bit CARRY_INIT = 1'b0
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       INST,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Z,
    output logic [3:0]       FLAGS
);

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [3:0]       s1_inst_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] z_r;
    logic [3:0]       flags_r;
    logic             c_r;

    logic             adv2_s;
    logic             adv1_s;
    logic             accept_s;

    logic [WIDTH-1:0] add_x_s;
    logic [WIDTH-1:0] add_y_s;
    logic             add_cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic             cy_s;
    logic             ov_s;
    logic             sticky_s;

    // Handshake: stage 2 frees when empty or retiring; stage 1 frees when empty or moving on.
    always_comb begin
        adv2_s   = ~out_valid_r | OUT_READY;
        adv1_s   = ~s1_valid_r | adv2_s;
        IN_READY = adv1_s & RESET_N;
        accept_s = IN_VALID & IN_READY;
    end

    // Adder operand selection: every arithmetic op is mapped onto x + y + cin,
    // subtraction and negation use the ~y + 1 form so carry means no-borrow.
    always_comb begin
        add_x_s   = {WIDTH{1'b0}};
        add_y_s   = {WIDTH{1'b0}};
        add_cin_s = 1'b0;
        case (s1_inst_r)
            4'b0000: begin add_x_s = s1_a_r;        add_y_s = {WIDTH{1'b0}}; add_cin_s = 1'b1; end
            4'b0001: begin add_x_s = s1_a_r;        add_y_s = {WIDTH{1'b1}}; add_cin_s = 1'b0; end
            4'b0010: begin add_x_s = s1_a_r;        add_y_s = s1_b_r;        add_cin_s = 1'b0; end
            4'b0011: begin add_x_s = s1_a_r;        add_y_s = ~s1_b_r;       add_cin_s = 1'b1; end
            4'b0100: begin
                // abs: negative operands become 0 - A, so the most-negative value overflows
                if (s1_a_r[WIDTH-1]) begin
                    add_x_s = {WIDTH{1'b0}}; add_y_s = ~s1_a_r; add_cin_s = 1'b1;
                end else begin
                    add_x_s = s1_a_r; add_y_s = {WIDTH{1'b0}}; add_cin_s = 1'b0;
                end
            end
            4'b0101: begin add_x_s = {WIDTH{1'b0}}; add_y_s = ~s1_a_r;       add_cin_s = 1'b1; end
            4'b0110: begin add_x_s = s1_a_r;        add_y_s = s1_b_r;        add_cin_s = c_r;  end
            4'b0111: begin add_x_s = {WIDTH{1'b0}}; add_y_s = ~s1_b_r;       add_cin_s = 1'b1; end
            default: begin add_x_s = {WIDTH{1'b0}}; add_y_s = {WIDTH{1'b0}}; add_cin_s = 1'b0; end
        endcase
        sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_cin_s};
    end

    // Result and flag generation for the op leaving stage 1.
    always_comb begin
        res_s = sum_s[WIDTH-1:0];
        cy_s  = 1'b0;
        ov_s  = 1'b0;
        case (s1_inst_r)
            4'b1000: res_s = s1_a_r & s1_b_r;
            4'b1001: res_s = s1_a_r | s1_b_r;
            4'b1010: res_s = s1_a_r ^ s1_b_r;
            4'b1011: res_s = ~s1_b_r;
            4'b1100: res_s = s1_a_r;
            4'b1101: res_s = ~s1_a_r;
            4'b1110: res_s = {WIDTH{1'b0}};
            4'b1111: res_s = {WIDTH{1'b1}};
            default: begin
                res_s = sum_s[WIDTH-1:0];
                cy_s  = sum_s[WIDTH];
                // signed overflow: like-signed adder inputs giving an opposite-signed sum
                ov_s  = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) &&
                        (sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
            end
        endcase
        if (s1_inst_r == 4'b1110) begin
            sticky_s = 1'b0;
        end else begin
            sticky_s = flags_r[3] | ov_s;
        end
    end

    // Pipeline registers, carry register and sticky overflow (held in flags_r[3]).
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= {WIDTH{1'b0}};
            s1_b_r      <= {WIDTH{1'b0}};
            s1_inst_r   <= 4'b0000;
            out_valid_r <= 1'b0;
            z_r         <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            c_r         <= CARRY_INIT;
        end else begin
            if (adv1_s) begin
                s1_valid_r <= accept_s;
                if (accept_s) begin
                    s1_a_r    <= A;
                    s1_b_r    <= B;
                    s1_inst_r <= INST;
                end
            end
            if (adv2_s) begin
                out_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    z_r     <= res_s;
                    flags_r <= {sticky_s, (res_s == {WIDTH{1'b0}}), cy_s, ov_s};
                    if (!s1_inst_r[3]) begin
                        c_r <= cy_s;
                    end
                end
            end
        end
    end

    assign OUT_VALID = out_valid_r;
    assign Z         = z_r;
    assign FLAGS     = flags_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Testbench for alu_pipe (WIDTH=32, CARRY_INIT=1): table of hand-computed
// vectors plus scoreboarded hand sequences and a random stream.
module tb_alu_pipe;

    localparam int W  = 32;
    localparam bit CI = 1'b1;

    logic         CLOCK = 1'b0;
    logic         RESET_N = 1'b0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [3:0]   INST = 4'b0000;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b1;
    logic [W-1:0] Z;
    logic [3:0]   FLAGS;

    alu_pipe #(.WIDTH(W), .CARRY_INIT(CI)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .INST(INST), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .Z(Z), .FLAGS(FLAGS)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] z;
        logic [3:0]  f;
    } vec_t;

    vec_t        tbl[25];
    logic [35:0] sb_q[$];   // {flags, z}
    int          checks = 0;
    int          errors = 0;
    logic        m_c;
    logic        m_st;
    bit          pend_model;
    logic [35:0] pend_exp;
    bit          last_acc;
    bit          rand_rdy = 1'b0;
    int          retired = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model, evaluated in acceptance order.
    task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                            output logic [35:0] r);
        longint      sa, sb, rs;
        logic [32:0] u;
        logic [31:0] z;
        logic        cy, ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rs = 0; cy = 1'b0; z = '0;
        case (op)
            4'd0:  begin rs = sa + 1; z = a + 32'd1; cy = (a == 32'hFFFFFFFF); end
            4'd1:  begin rs = sa - 1; z = a - 32'd1; cy = (a != 32'd0); end
            4'd2:  begin rs = sa + sb; u = {1'b0, a} + {1'b0, b}; z = u[31:0]; cy = u[32]; end
            4'd3:  begin rs = sa - sb; z = a - b; cy = (a >= b); end
            4'd4:  begin
                       if (sa < 0) begin rs = -sa; z = 32'd0 - a; end
                       else begin rs = sa; z = a; end
                       cy = 1'b0;
                   end
            4'd5:  begin rs = -sa; z = 32'd0 - a; cy = (a == 32'd0); end
            4'd6:  begin
                       rs = sa + sb + longint'(m_c);
                       u = {1'b0, a} + {1'b0, b} + {32'd0, m_c};
                       z = u[31:0]; cy = u[32];
                   end
            4'd7:  begin rs = -sb; z = 32'd0 - b; cy = (b == 32'd0); end
            4'd8:  z = a & b;
            4'd9:  z = a | b;
            4'd10: z = a ^ b;
            4'd11: z = ~b;
            4'd12: z = a;
            4'd13: z = ~a;
            4'd14: z = 32'd0;
            default: z = 32'hFFFFFFFF;
        endcase
        ov = !op[3] && ((rs > 64'sd2147483647) || (rs < -64'sd2147483648));
        if (!op[3]) m_c = cy;
        m_st = (op == 4'd14) ? 1'b0 : (m_st | ov);
        r = {m_st, (z == 32'd0), cy, ov, z};
    endtask

    // One clock: sample handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        logic [35:0] e;
        @(negedge CLOCK);
        last_acc = IN_VALID && IN_READY;
        if (OUT_VALID === 1'b1 && OUT_READY) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_result: got Z=%h FLAGS=%b required none", Z, FLAGS);
            end else begin
                e = sb_q.pop_front();
                check("result_z", 64'(Z), 64'(e[31:0]));
                check("result_flags", 64'(FLAGS), 64'(e[35:32]));
                retired++;
            end
        end
        if (last_acc) begin
            if (pend_model) model_op(A, B, INST, e);
            else e = pend_exp;
            sb_q.push_back(e);
        end
        @(posedge CLOCK);
        #1;
        if (rand_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input bit use_model, input logic [35:0] exp, output int n);
        A = a; B = b; INST = op; IN_VALID = 1'b1;
        pend_model = use_model; pend_exp = exp;
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 200);
        if (!last_acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles required accept", n);
        end
    endtask

    task automatic drain(output int n);
        IN_VALID = 1'b0;
        n = 0;
        while (sb_q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        IN_VALID = 1'b1; A = 32'h1234; B = 32'h1; INST = 4'b0010;
        @(negedge CLOCK);
        check("ready_in_reset", 64'(IN_READY), 64'd0);
        @(posedge CLOCK); #1;
        check("reset_out_valid", 64'(OUT_VALID), 64'd0);
        check("reset_flags", 64'(FLAGS), 64'd0);
        check("reset_z", 64'(Z), 64'd0);
        @(posedge CLOCK); #1;
        RESET_N = 1'b1;
        IN_VALID = 1'b0;
        sb_q.delete();
        m_c = CI;
        m_st = 1'b0;
        #1;
        check("ready_after_reset", 64'(IN_READY), 64'd1);
    endtask

    initial begin
        int n, tot;
        logic [31:0] ra, rb;
        logic [31:0] corner[6];

        tbl[0]  = '{32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 4'b1001};
        tbl[1]  = '{32'h00000000, 32'h00000000, 4'b1110, 32'h00000000, 4'b0100};
        tbl[2]  = '{32'hFFFFFFFF, 32'h00000001, 4'b0010, 32'h00000000, 4'b0110};
        tbl[3]  = '{32'h00000000, 32'h00000000, 4'b0110, 32'h00000001, 4'b0000};
        tbl[4]  = '{32'h00000005, 32'h00000007, 4'b0011, 32'hFFFFFFFE, 4'b0000};
        tbl[5]  = '{32'h00000007, 32'h00000007, 4'b0011, 32'h00000000, 4'b0110};
        tbl[6]  = '{32'h00000000, 32'h00000000, 4'b0001, 32'hFFFFFFFF, 4'b0000};
        tbl[7]  = '{32'h80000000, 32'h00000000, 4'b0001, 32'h7FFFFFFF, 4'b1011};
        tbl[8]  = '{32'hFFFFFFFF, 32'h00000000, 4'b0000, 32'h00000000, 4'b1110};
        tbl[9]  = '{32'h80000000, 32'h00000000, 4'b0100, 32'h80000000, 4'b1001};
        tbl[10] = '{32'hFFFFFFFD, 32'h00000000, 4'b0100, 32'h00000003, 4'b1000};
        tbl[11] = '{32'h00000000, 32'h00000000, 4'b0101, 32'h00000000, 4'b1110};
        tbl[12] = '{32'h00000000, 32'h80000000, 4'b0111, 32'h80000000, 4'b1001};
        tbl[13] = '{32'hFFFFFFFF, 32'h00000000, 4'b0110, 32'hFFFFFFFF, 4'b1000};
        tbl[14] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b1000, 32'hF000F000, 4'b1000};
        tbl[15] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b1001, 32'hFFF0FFF0, 4'b1000};
        tbl[16] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b1010, 32'h0FF00FF0, 4'b1000};
        tbl[17] = '{32'hF0F0F0F0, 32'hFF00FF00, 4'b1011, 32'h00FF00FF, 4'b1000};
        tbl[18] = '{32'h12345678, 32'h00000000, 4'b1100, 32'h12345678, 4'b1000};
        tbl[19] = '{32'hFFFFFFFF, 32'h00000000, 4'b1101, 32'h00000000, 4'b1100};
        tbl[20] = '{32'h00000000, 32'h00000000, 4'b1111, 32'hFFFFFFFF, 4'b1000};
        tbl[21] = '{32'h00000000, 32'h00000000, 4'b1110, 32'h00000000, 4'b0100};
        tbl[22] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0010, 32'hFFFFFFFE, 4'b0010};
        tbl[23] = '{32'h00000000, 32'h00000000, 4'b1100, 32'h00000000, 4'b0100};
        tbl[24] = '{32'h00000001, 32'h00000001, 4'b0110, 32'h00000003, 4'b0000};

        corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'h7FFFFFFF;
        corner[3] = 32'h80000000; corner[4] = 32'hFFFFFFFF; corner[5] = 32'h5;

        do_reset();

        // Streamed table with OUT_READY high: one accept per cycle, results back-to-back.
        tot = 0;
        for (int i = 0; i < 25; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].op, 1'b0, {tbl[i].f, tbl[i].z}, n);
            tot += n;
        end
        check("table_no_stall_cycles", 64'(tot), 64'd25);
        drain(n);
        check("table_drain_cycles", 64'(n), 64'd2);

        do_reset();

        // Latency: presented after edge 0, captured at edge 1, visible after edge 2.
        issue(32'd10, 32'd20, 4'b0010, 1'b1, 36'd0, n);
        check("latency_edge1_valid", 64'(OUT_VALID), 64'd0);
        IN_VALID = 1'b0;
        step();
        check("latency_edge2_valid", 64'(OUT_VALID), 64'd1);
        check("latency_edge2_z", 64'(Z), 64'd30);
        drain(n);

        // Back-pressure: two accepts fill the pipe, the third waits for OUT_READY.
        retired = 0;
        OUT_READY = 1'b0;
        issue(32'd100, 32'd1, 4'b0011, 1'b1, 36'd0, n);
        issue(32'd3, 32'd4, 4'b0010, 1'b1, 36'd0, n);
        A = 32'hAAAA5555; B = 32'h0F0F0F0F; INST = 4'b1010; IN_VALID = 1'b1; pend_model = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_in_ready_low", 64'(IN_READY), 64'd0);
            check("bp_z_hold", 64'(Z), 64'd99);
            check("bp_out_valid", 64'(OUT_VALID), 64'd1);
            step();
            check("bp_no_accept", 64'(last_acc), 64'd0);
        end
        OUT_READY = 1'b1;
        #1;
        check("bp_in_ready_release", 64'(IN_READY), 64'd1);
        step();
        check("bp_accept_on_retire", 64'(last_acc), 64'd1);
        drain(n);
        check("bp_retired_count", 64'(retired), 64'd3);

        // Random stream with random back-pressure and bubbles.
        rand_rdy = 1'b1;
        for (int i = 0; i < 80; i++) begin
            ra = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
            issue(ra, rb, 4'($urandom_range(0, 15)), 1'b1, 36'd0, n);
            if ($urandom_range(0, 4) == 0) begin
                IN_VALID = 1'b0;
                step();
            end
        end
        drain(n);
        rand_rdy = 1'b0;
        OUT_READY = 1'b1;

        // Reset with both stages full drops everything and restores C.
        OUT_READY = 1'b0;
        issue(32'hFFFFFFFF, 32'd1, 4'b0010, 1'b1, 36'd0, n);
        issue(32'h7FFFFFFF, 32'd1, 4'b0010, 1'b1, 36'd0, n);
        IN_VALID = 1'b0;
        #1;
        check("full_before_reset", 64'(OUT_VALID), 64'd1);
        do_reset();
        OUT_READY = 1'b1;
        issue(32'd0, 32'd0, 4'b0110, 1'b0, {4'b0000, 32'd1}, n);
        drain(n);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
